pixel_mem_ctrl: RTL
===================

Name: pixel_mem_ctrl

Overview:
Controller that sequences the 32x32x3 local pixel memory for one convolution layer. LOAD phase: accepts a planar pixel stream (R plane, then G, then B) and generates the memory write strobes and addresses. SCAN phase: walks every output centre in raster order and reads the 9 taps of its 3x3 window. Out-of-image taps are zero-padded. Each tap goes to the PE array over a valid/ready handshake. Sits between the DMA/bus input port and the pixel memory / PE array.

Parameters:
IMG_W, 32, image width in pixels; must be a power of 2, at most 32.
IMG_H, 32, image height in pixels; at most 32.
DW, 16, pixel channel width in bits.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  single-cycle pulse; begins LOAD; honoured only in IDLE
in_data  in  DW  incoming pixel word
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts in_data
write_pixel_signal  out  1  memory write strobe
write_pixel_addr  out  16  {4'b0, ch[1:0], row[4:0], col[4:0]}
write_pixel_data  out  DW  equals in_data
read_pixel_signal  out  1  memory read enable
read_pixel_addr  out  16  {6'b0, row[4:0], col[4:0]}
read_pixel_data  in  3*DW  {B,G,R} from memory; combinational, same cycle
out_pixel  out  3*DW  window tap {B,G,R}; zero for padded taps
out_tap  out  4  tap index 0..8: (dr,dc) = (tap/3-1, tap%3-1)
out_row  out  5  centre row
out_col  out  5  centre column
out_valid  out  1  tap valid
out_ready  in  1  PE accepts tap
busy  out  1  state is LOAD or SCAN
done  out  1  one-cycle pulse when the scan completes

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset: state IDLE; all counters 0; done 0; busy 0. All strobes (in_ready, write_pixel_signal, read_pixel_signal, out_valid) are 0 and all address/data outputs 0 in IDLE. Memory contents are not touched by the controller.
- rst asserted in any state: IDLE on the next edge. Any partial load or scan is abandoned.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE -> LOAD on start. start in any other state is ignored.
- LOAD:
  - in_ready = 1.
  - write_pixel_signal = in_valid (combinational); write_pixel_data = in_data.
  - Load counter cnt runs 0..3*IMG_W*IMG_H-1 and advances only on an accepted word (in_valid & in_ready).
  - Address fields: ch = cnt / (IMG_W*IMG_H); pixel index p = cnt % (IMG_W*IMG_H); row = p / IMG_W; col = p % IMG_W.
  - in_valid gaps stall the count; no write occurs during a gap.
  - Accepting the final word moves LOAD -> SCAN on the next edge. There is no SCAN cycle overlapping a write.
- SCAN:
  - out_valid = 1.
  - Tap coordinates: tr = row + dr, tc = col + dc, with (dr,dc) taken from out_tap.
  - in_range = (0 <= tr < IMG_H) and (0 <= tc < IMG_W).
  - read_pixel_signal = in_range; read_pixel_addr = {tr,tc} when in_range, else 0.
  - out_pixel = read_pixel_data when in_range, else 0 (zero latency, combinational).
  - Advance on out_valid & out_ready: tap 8 -> tap 0 and col+1; col wrap -> col 0 and row+1.
  - With out_ready low, all SCAN outputs are held stable.
  - The handshake on centre (IMG_H-1, IMG_W-1), tap 8, moves SCAN -> DONE.
- Signed arithmetic: tr and tc use 7-bit signed arithmetic so that -1 and IMG_W are detected without wrap-around.
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE. A start that arrives while in DONE is ignored.
- Total SCAN handshakes: 9*IMG_W*IMG_H (9216 at defaults).

Test Plan:
- Reset values: assert rst for 2 cycles with in_valid=1 and start=1 -> in_ready, write_pixel_signal, out_valid, busy, done all 0; state IDLE.
- Load addressing: start, then 3072 words with in_data = index, no gaps. Required writes: word 0 -> addr 0x0000; word 33 -> 0x0021; word 1056 -> 0x0420 (G, row 1, col 0); word 3071 -> 0x0BFF. busy=1 throughout. out_valid rises the cycle after word 3071.
- Load stalls and stray start: drop in_valid for 5 cycles mid-load and pulse start -> no write_pixel_signal during the gap, count resumes unchanged, start has no effect, and exactly 3072 writes occur in total.
- Corner padding: first centre (0,0). Taps 0,1,2,3,6 -> out_pixel 0 and read_pixel_signal 0. Tap 4 -> addr 0x0000; tap 5 -> 0x0001; tap 7 -> 0x0020; tap 8 -> 0x0021. Centre (31,31) zero-pads taps 2,5,6,7,8.
- Backpressure: hold out_ready=0 for 10 cycles at centre (5,7) tap 3 -> out_tap=3, read_pixel_addr=0x00A6 and out_pixel all stable. Release -> next tap 4 at addr 0x00A7.
- Completion and reset mid-scan: with out_ready=1 the run yields 9216 handshakes, then done high for exactly 1 cycle, busy=0, and IDLE. In a separate run, assert rst during SCAN at centre (10,10) -> IDLE and out_valid=0 next cycle. A new start plus reload repeats the scan from (0,0) tap 0.

Source files
------------

// File: rtl/pixel_mem_ctrl_if.sv
// Bus bundle between the pixel memory controller and its surroundings:
// DMA input stream, pixel memory write/read ports and the PE tap stream.
interface pixel_mem_ctrl_if #(
    parameter int DW = 16
);
    logic              start;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic              write_pixel_signal;
    logic [15:0]       write_pixel_addr;
    logic [DW-1:0]     write_pixel_data;
    logic              read_pixel_signal;
    logic [15:0]       read_pixel_addr;
    logic [3*DW-1:0]   read_pixel_data;
    logic [3*DW-1:0]   out_pixel;
    logic [3:0]        out_tap;
    logic [4:0]        out_row;
    logic [4:0]        out_col;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, in_data, in_valid, read_pixel_data, out_ready,
        output in_ready, write_pixel_signal, write_pixel_addr, write_pixel_data,
               read_pixel_signal, read_pixel_addr, out_pixel, out_tap,
               out_row, out_col, out_valid, busy, done
    );

    modport slave (
        output start, in_data, in_valid, read_pixel_data, out_ready,
        input  in_ready, write_pixel_signal, write_pixel_addr, write_pixel_data,
               read_pixel_signal, read_pixel_addr, out_pixel, out_tap,
               out_row, out_col, out_valid, busy, done
    );
endinterface

// File: rtl/pixel_mem_ctrl.sv
// Sequences the 32x32x3 pixel memory: LOAD writes a planar R/G/B stream,
// SCAN streams the zero-padded 3x3 window taps of every centre to the PE array.
module pixel_mem_ctrl #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int DW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    pixel_mem_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    localparam logic [4:0]        COL_LAST = 5'(IMG_W - 1);
    localparam logic [4:0]        ROW_LAST = 5'(IMG_H - 1);
    localparam logic signed [6:0] W_S      = 7'(IMG_W);
    localparam logic signed [6:0] H_S      = 7'(IMG_H);

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic [3:0]  tap_q, tap_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic              loading;
    logic              scanning;
    logic              accept;
    logic signed [6:0] dr, dc, tr, tc;
    logic              in_range;

    assign loading  = (state_q == LOAD);
    assign scanning = (state_q == SCAN);
    assign accept   = loading && bus.in_valid;

    // Window offsets: taps 0..8 cover (dr,dc) in raster order around the centre.
    always_comb begin
        dr = 7'sd1;
        dc = 7'sd1;
        case (tap_q)
            4'd0, 4'd1, 4'd2: dr = -7'sd1;
            4'd3, 4'd4, 4'd5: dr = 7'sd0;
            default:          dr = 7'sd1;
        endcase
        case (tap_q)
            4'd0, 4'd3, 4'd6: dc = -7'sd1;
            4'd1, 4'd4, 4'd7: dc = 7'sd0;
            default:          dc = 7'sd1;
        endcase
    end

    assign tr       = $signed({2'b00, row_q}) + dr;
    assign tc       = $signed({2'b00, col_q}) + dc;
    assign in_range = (tr >= 7'sd0) && (tr < H_S) && (tc >= 7'sd0) && (tc < W_S);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        row_d   = row_q;
        col_d   = col_q;
        tap_d   = tap_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    ch_d    = 2'd0;
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                    tap_d   = 4'd0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = 5'd0;
                        if (row_q == ROW_LAST) begin
                            row_d = 5'd0;
                            if (ch_q == 2'd2) begin
                                ch_d    = 2'd0;
                                state_d = SCAN;
                            end else begin
                                ch_d = ch_q + 2'd1;
                            end
                        end else begin
                            row_d = row_q + 5'd1;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    if (tap_q == 4'd8) begin
                        tap_d = 4'd0;
                        if (col_q == COL_LAST) begin
                            col_d = 5'd0;
                            if (row_q == ROW_LAST) begin
                                row_d   = 5'd0;
                                state_d = DONE;
                            end else begin
                                row_d = row_q + 5'd1;
                            end
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end else begin
                        tap_d = tap_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == SCAN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            row_q   <= 5'd0;
            col_q   <= 5'd0;
            tap_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tap_q   <= tap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Everything outside its own phase is forced to zero so IDLE looks quiet.
    assign bus.in_ready           = loading;
    assign bus.write_pixel_signal = accept;
    assign bus.write_pixel_addr   = loading ? {4'b0000, ch_q, row_q, col_q} : 16'h0000;
    assign bus.write_pixel_data   = loading ? bus.in_data : '0;

    assign bus.out_valid          = scanning;
    assign bus.read_pixel_signal  = scanning && in_range;
    assign bus.read_pixel_addr    = bus.read_pixel_signal ? {6'b000000, tr[4:0], tc[4:0]} : 16'h0000;
    assign bus.out_pixel          = bus.read_pixel_signal ? bus.read_pixel_data : '0;
    assign bus.out_tap            = scanning ? tap_q : 4'd0;
    assign bus.out_row            = scanning ? row_q : 5'd0;
    assign bus.out_col            = scanning ? col_q : 5'd0;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;

endmodule
